// File: rtl/mem_resp_pipe.sv
// Byte-enabled single-port memory with a fixed-latency in-order response
// pipeline, a saturating request counter and a sticky program-end detector.
module mem_resp_pipe #(
    parameter int          MEM_W       = 32,
    parameter int          MEM_SZ      = 65536,
    parameter int          MEM_LATENCY = 1,
    parameter logic [31:0] END_ADDR    = 32'h0000_0000
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               mem_req_i,
    input  logic [31:0]        mem_addr_i,
    input  logic               mem_we_i,
    input  logic [MEM_W/8-1:0] mem_be_i,
    input  logic [MEM_W-1:0]   mem_wdata_i,
    output logic               mem_rvalid_o,
    output logic               mem_err_o,
    output logic [MEM_W-1:0]   mem_rdata_o,
    output logic               prog_end_o,
    output logic [31:0]        req_cnt_o
);

    localparam int NB    = MEM_W / 8;
    localparam int AW    = $clog2(MEM_SZ);
    localparam int OW    = $clog2(NB);
    localparam int DEPTH = MEM_SZ / NB;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    logic [MEM_W-1:0] mem [DEPTH];

    logic                   in_range;
    logic [AW-OW-1:0]       idx;
    logic [MEM_LATENCY-1:0] vld_q;
    logic [MEM_LATENCY-1:0] err_q;
    logic [MEM_LATENCY-1:0][MEM_W-1:0] dat_q;
    logic [31:0]            cnt_q;
    logic                   end_q;
    state_t                 state_q;
    state_t                 state_n;

    assign in_range = (mem_addr_i >> AW) == 32'd0;
    assign idx      = mem_addr_i[AW-1:OW];

    // Byte-enabled write; memory keeps its contents across reset and
    // requests sampled during reset never write.
    always_ff @(posedge clk_i) begin
        if (mem_req_i && !rst_i && mem_we_i && in_range) begin
            for (int b = 0; b < NB; b++) begin
                if (mem_be_i[b]) begin
                    mem[idx][8*b +: 8] <= mem_wdata_i[8*b +: 8];
                end
            end
        end
    end

    // Response shift pipeline; stage 0 samples the pre-write word.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_q <= '0;
            err_q <= '0;
            dat_q <= '0;
        end else begin
            vld_q[0] <= mem_req_i;
            err_q[0] <= mem_req_i & ~in_range;
            dat_q[0] <= (mem_req_i && in_range) ? mem[idx] : '0;
            for (int i = 1; i < MEM_LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
                err_q[i] <= err_q[i-1];
                dat_q[i] <= dat_q[i-1];
            end
        end
    end

    // Saturating count of accepted requests.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (mem_req_i && cnt_q != 32'hFFFF_FFFF) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    // End-detector state register and registered end flag.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            end_q   <= 1'b0;
        end else begin
            state_q <= state_n;
            end_q   <= (state_n == DONE);
        end
    end

    // End-detector next state; an END_ADDR hit before any other request
    // is the boot fetch and does not end the program.
    always_comb begin
        state_n = state_q;
        case (state_q)
            IDLE: begin
                if (mem_req_i && mem_addr_i != END_ADDR) begin
                    state_n = RUN;
                end
            end
            RUN: begin
                if (mem_req_i && mem_addr_i == END_ADDR) begin
                    state_n = DONE;
                end
            end
            DONE:    state_n = DONE;
            default: state_n = IDLE;
        endcase
    end

    assign mem_rvalid_o = vld_q[MEM_LATENCY-1];
    assign mem_err_o    = err_q[MEM_LATENCY-1];
    assign mem_rdata_o  = dat_q[MEM_LATENCY-1];
    assign prog_end_o   = end_q;
    assign req_cnt_o    = cnt_q;

endmodule

// File: tb/tb_mem_resp_pipe.sv
// Scoreboard bench for mem_resp_pipe: directed requests push expected
// responses, an independent monitor checks every response cycle.
module tb_mem_resp_pipe;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic [31:0] addr = '0;
    logic        we = 1'b0;
    logic [3:0]  be = '0;
    logic [31:0] wdata = '0;
    logic        rvalid;
    logic        err;
    logic [31:0] rdata;
    logic        prog_end;
    logic [31:0] req_cnt;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    typedef struct {
        int          due;
        bit          chk;
        logic        err;
        logic [31:0] data;
    } exp_t;

    exp_t q[$];

    mem_resp_pipe #(
        .MEM_W(32),
        .MEM_SZ(65536),
        .MEM_LATENCY(LAT),
        .END_ADDR(32'h0000_0000)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .mem_req_i(req),
        .mem_addr_i(addr),
        .mem_we_i(we),
        .mem_be_i(be),
        .mem_wdata_i(wdata),
        .mem_rvalid_o(rvalid),
        .mem_err_o(err),
        .mem_rdata_o(rdata),
        .prog_end_o(prog_end),
        .req_cnt_o(req_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops one expectation per response and checks latency,
    // error and data; also flags missing or unexpected responses.
    always @(posedge clk) begin
        #1;
        if (!rst) begin
            if (rvalid) begin
                tests++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_resp cyc=%0d err=%b rdata=%h",
                             cyc, err, rdata);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    if (cyc != e.due || err !== e.err ||
                        (e.chk && rdata !== e.data)) begin
                        fails++;
                        $display("FAIL resp cyc=%0d err=%b rdata=%h, need cyc=%0d err=%b rdata=%h",
                                 cyc, err, rdata, e.due, e.err, e.data);
                    end
                end
            end else begin
                tests++;
                if (err !== 1'b0 || rdata !== 32'h0) begin
                    fails++;
                    $display("FAIL idle_zero err=%b rdata=%h, need 0", err, rdata);
                end
                if (q.size() > 0 && cyc >= q[0].due) begin
                    fails++;
                    $display("FAIL missing_resp cyc=%0d, need rvalid at %0d",
                             cyc, q[0].due);
                    void'(q.pop_front());
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s got %h, need %h", name, act, exp);
        end
    endtask

    task automatic issue(input logic w, input logic [31:0] a,
                         input logic [3:0] b, input logic [31:0] d,
                         input bit chk, input logic e,
                         input logic [31:0] x);
        exp_t t;
        @(negedge clk);
        req   = 1'b1;
        we    = w;
        addr  = a;
        be    = b;
        wdata = d;
        t.due  = cyc + LAT;
        t.chk  = chk;
        t.err  = e;
        t.data = x;
        q.push_back(t);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            req = 1'b0;
            we  = 1'b0;
        end
    endtask

    initial begin
        // reset state
        repeat (2) @(negedge clk);
        check("rst_rvalid", {31'b0, rvalid}, 32'h0);
        check("rst_prog_end", {31'b0, prog_end}, 32'h0);
        check("rst_cnt", req_cnt, 32'h0);
        check("rst_rdata", rdata, 32'h0);
        rst = 1'b0;

        // program-end detection (boot fetch of 0 is not an end)
        issue(1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        @(posedge clk); #1;
        check("boot_no_end", {31'b0, prog_end}, 32'h0);
        issue(1'b0, 32'h4, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        issue(1'b0, 32'h8, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        issue(1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        check("end_before_edge", {31'b0, prog_end}, 32'h0);
        @(posedge clk); #1;
        check("end_rise", {31'b0, prog_end}, 32'h1);
        check("cnt_4", req_cnt, 32'd4);

        // full write, read back
        issue(1'b1, 32'h1000, 4'hF, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0);
        issue(1'b0, 32'h1000, 4'h0, 32'h0, 1'b1, 1'b0, 32'hDEADBEEF);
        // partial write returns pre-write word, read back merged
        issue(1'b1, 32'h1000, 4'b0101, 32'h11223344, 1'b1, 1'b0, 32'hDEADBEEF);
        issue(1'b0, 32'h1000, 4'h0, 32'h0, 1'b1, 1'b0, 32'hDE22BE44);
        issue(1'b0, 32'h1003, 4'h0, 32'h0, 1'b1, 1'b0, 32'hDE22BE44);
        // out of range
        issue(1'b1, 32'h0, 4'hF, 32'h12345678, 1'b0, 1'b0, 32'h0);
        issue(1'b1, 32'h0001_0000, 4'hF, 32'hFFFFFFFF, 1'b1, 1'b1, 32'h0);
        issue(1'b0, 32'h0001_0000, 4'h0, 32'h0, 1'b1, 1'b1, 32'h0);
        issue(1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0, 32'h12345678);
        // same-cycle read-before-write
        issue(1'b1, 32'h20, 4'hF, 32'hA5A5A5A5, 1'b0, 1'b0, 32'h0);
        issue(1'b1, 32'h20, 4'hF, 32'h5A5A5A5A, 1'b1, 1'b0, 32'hA5A5A5A5);
        issue(1'b0, 32'h20, 4'h0, 32'h0, 1'b1, 1'b0, 32'h5A5A5A5A);
        idle(LAT + 2);
        check("drain1", q.size(), 32'd0);
        check("end_sticky", {31'b0, prog_end}, 32'h1);
        check("cnt_16", req_cnt, 32'd16);

        // reset discards in-flight reads
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = 32'h1000;
        @(negedge clk);
        addr = 32'h20;
        @(negedge clk);
        req = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_mid_rvalid", {31'b0, rvalid}, 32'h0);
        check("rst_mid_cnt", req_cnt, 32'h0);
        check("rst_mid_end", {31'b0, prog_end}, 32'h0);
        idle(2);
        rst = 1'b0;
        idle(LAT + 2);
        check("post_rst_cnt", req_cnt, 32'h0);
        issue(1'b0, 32'h1000, 4'h0, 32'h0, 1'b1, 1'b0, 32'hDE22BE44);
        idle(LAT + 2);
        check("drain2", q.size(), 32'd0);
        check("post_rst_cnt1", req_cnt, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
